mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Single-port memory arbiter between the Icache refill port, the Dcache refill port and the
//  Dcache write-back port on one side, and the cpu-level memory bus on the other side.
//  It serialises line transfers with a registered FSM and applies fixed priority with an anti-starvation override.
//  One transaction is outstanding at a time; address/data are latched at grant.
// PARAMETERS
//  ADDR_W      32   byte address width (REG_SIZE)
//  LINE_W      128  cache line / memory data width (WIDTH)
//  STARVE_MAX  4    consecutive Dcache grants while IC waits before IC is forced first (>=1)
// PORTS
//  clk             in   1       clock; all logic on posedge
//  reset           in   1       synchronous, active-low reset
//  ic_read_req     in   1       Icache line read request (level, held until ack)
//  ic_read_addr    in   ADDR_W  Icache line address
//  ic_read_data    out  LINE_W  read line returned to Icache
//  ic_read_ack     out  1       1-cycle pulse: ic_read_data valid, request done
//  dc_read_req     in   1       Dcache line read request
//  dc_read_addr    in   ADDR_W  Dcache read address
//  dc_read_data    out  LINE_W  read line returned to Dcache
//  dc_read_ack     out  1       1-cycle pulse: dc_read_data valid
//  dc_write_req    in   1       Dcache write-back request
//  dc_write_addr   in   ADDR_W  write-back address
//  dc_write_data   in   LINE_W  write-back line
//  dc_write_ack    out  1       1-cycle pulse: write committed
//  mem_enable      out  1       memory transaction active (held until mem_ack)
//  mem_rw          out  1       1 = write, 0 = read
//  mem_ack         in   1       memory completion pulse
//  mem_addr        out  ADDR_W  latched transaction address
//  mem_data_in     in   LINE_W  read data from memory, valid with mem_ack
//  mem_data_out    out  LINE_W  write data to memory, latched at grant
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; all outputs 0; starve counter 0. Applies mid-transaction:
//    the in-flight transfer is abandoned, no ack issued; requesters reissue after reset.
//  - States: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if any req high at posedge, grant one, latch addr (and data/rw for write); next cycle
//    state BUSY, mem_enable=1. No req -> stay IDLE, mem_enable=0.
//  - Priority: dc_write > dc_read > ic_read. Override: if starve==STARVE_MAX and ic_read_req,
//    IC is granted regardless.
//  - starve: +1 (saturating at STARVE_MAX) on each Dcache grant while ic_read_req is high; cleared on an IC grant
//    or when ic_read_req is low in IDLE.
//  - BUSY: mem_enable, mem_rw, mem_addr, mem_data_out held stable. On mem_ack: capture mem_data_in
//    into the grantee's read_data register (reads only); next cycle state RESP, mem_enable=0.
//  - RESP: exactly one cycle; grantee ack=1; read_data valid and held until the next grant of that port.
//    Next state IDLE.
//  - Latency: req seen at edge t -> mem_enable at t+1; mem_ack at edge k -> ack high in cycle k+1.
//    Min req-to-ack: 3 cycles with 1-cycle memory.
//  - Requester rule: deassert req (or change to a new address) in the cycle after ack. IDLE samples only
//    after RESP, so a held req is treated as a new request.
//  - Req changes during BUSY are ignored (latched values used); a req dropped mid-BUSY still completes
//    and is still acked.
//  - mem_ack outside BUSY is ignored. Simultaneous reqs never produce two acks in one cycle.
//  - At most one of the three ack outputs is high in any cycle.
// TESTING
//  1 Reset: drive reset=0 with all reqs=1 -> all outputs 0; release -> dc_write granted first.
//  2 IC read addr=0x40, mem_ack 2 cycles after mem_enable with data 0xA5.. -> mem_rw=0, mem_addr=0x40,
//    ic_read_ack 1 cycle, ic_read_data=0xA5...
//  3 dc_write addr=0x80, data=0x1234 together with dc_read and ic_read -> order: write (mem_rw=1,
//    mem_data_out=0x1234), then dc_read, then ic_read; three separate ack pulses.
//  4 Starvation: ic_read_req held, dc reqs continuously reissued, STARVE_MAX=4 -> IC is granted after 4 Dcache grants.
//  5 reset=0 during BUSY with mem_ack arriving the same cycle -> no ack issued, state IDLE, mem_enable=0 next cycle.
//  6 Spurious mem_ack in IDLE -> no ack outputs, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises Icache refill, Dcache refill and Dcache
// write-back line transfers onto one memory bus, one transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic [LINE_W-1:0] ic_read_data,
  output logic              ic_read_ack,

  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              dc_read_ack,

  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,

  output logic              mem_enable,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IC   = 2'd1,
    G_DR   = 2'd2,
    G_DW   = 2'd3
  } grant_t;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  state_t           state;
  state_t           state_next;
  grant_t           grant;
  grant_t           grant_sel;
  logic [CNT_W-1:0] starve_cnt;
  logic             any_req;
  logic             ic_forced;
  logic             dc_grant_sel;

  assign any_req      = ic_read_req | dc_read_req | dc_write_req;
  assign ic_forced    = ic_read_req && (starve_cnt == STARVE_LIMIT);
  assign dc_grant_sel = (grant_sel == G_DR) || (grant_sel == G_DW);

  // Fixed priority write > read > icache, unless the Icache has waited out
  // STARVE_MAX consecutive Dcache grants.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_sel = G_NONE;
    if (ic_forced)         grant_sel = G_IC;
    else if (dc_write_req) grant_sel = G_DW;
    else if (dc_read_req)  grant_sel = G_DR;
    else if (ic_read_req)  grant_sel = G_IC;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: enable and acks are pure decodes of the registered state.
  always_comb begin
    mem_enable   = (state == BUSY);
    ic_read_ack  = 1'b0;
    dc_read_ack  = 1'b0;
    dc_write_ack = 1'b0;
    if (state == RESP) begin
      ic_read_ack  = (grant == G_IC);
      dc_read_ack  = (grant == G_DR);
      dc_write_ack = (grant == G_DW);
    end
  end

  // Transaction latch: address, direction and write data frozen at grant time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant        <= G_NONE;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else if (state == IDLE && any_req) begin
      grant        <= grant_sel;
      mem_rw       <= (grant_sel == G_DW);
      mem_data_out <= (grant_sel == G_DW) ? dc_write_data : '0;
      unique case (grant_sel)
        G_IC:    mem_addr <= ic_read_addr;
        G_DR:    mem_addr <= dc_read_addr;
        G_DW:    mem_addr <= dc_write_addr;
        default: mem_addr <= '0;
      endcase
    end
  end

  // Read-return registers hold their line until that port's next refill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ic_read_data <= '0;
      dc_read_data <= '0;
    end else if (state == BUSY && mem_ack) begin
      if (grant == G_IC) ic_read_data <= mem_data_in;
      if (grant == G_DR) dc_read_data <= mem_data_in;
    end
  end

  // Counts Dcache wins while the Icache is left waiting; decisions only in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!ic_read_req || grant_sel == G_IC)
        starve_cnt <= '0;
      else if (dc_grant_sel && starve_cnt != STARVE_LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
